term_write_ctrl: RTL and testbench

Writer side of the recirculating character memory. The memory is a CHAR_W-wide bank of 1024-bit shift registers clocked every `clk`. This block normally recirculates `mem_so` back into `mem_si`. When the delay line presents the cursor slot, it substitutes the incoming character. It also handles CR, line wrap, row-rotation scrolling and full-screen clear, and exports `cursor_addr`/`top_row` to the video reader.

---
 rtl/term_pkg.sv | 37 +++
 rtl/term_write_ctrl_if.sv | 37 +++
 rtl/term_cursor.sv | 79 +++++++
 rtl/term_write_ctrl.sv | 155 +++++++++++++++
 tb/tb_term_write_ctrl.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/term_pkg.sv
`default_nettype none
// ============================================================================
// Module      : term_pkg
// Description : Shared constants for the terminal writer: screen geometry,
//               special character codes, the writer FSM state encoding and a
//               row-to-address helper.
// Revision    : 1.0  initial release
// ============================================================================
package term_pkg;

  localparam int COLS         = 40;
  localparam int ROWS         = 24;
  localparam int SCREEN_CHARS = COLS * ROWS;

  localparam int ADDR_W = 10;
  localparam int ROW_W  = 5;
  localparam int COL_W  = 6;

  localparam logic [6:0] ASCII_CR   = 7'h0D;
  localparam logic [5:0] BLANK_CHAR = 6'h20;

  // Writer FSM state encoding
  localparam logic [2:0] ST_CLEAR      = 3'd0;
  localparam logic [2:0] ST_IDLE       = 3'd1;
  localparam logic [2:0] ST_SEEK       = 3'd2;
  localparam logic [2:0] ST_BLANK_WAIT = 3'd3;
  localparam logic [2:0] ST_BLANK      = 3'd4;
  localparam logic [2:0] ST_NEWLINE    = 3'd5;  // one-cycle CR handling

  // First memory address of a physical row
  function automatic logic [ADDR_W-1:0] row_start(input logic [ROW_W-1:0] row,
                                                  input int cols);
    return ADDR_W'(int'(row) * cols);
  endfunction

endpackage
`default_nettype wire

// File: rtl/term_write_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : term_write_ctrl_if
// Description : Bus bundle between the terminal writer, its character
//               producer, the recirculating memory and the video reader.
//   char_in/char_valid/char_ready : character handshake
//   clr                           : clear-screen request
//   mem_so/mem_si                 : memory tap output / memory input
//   head/cursor_addr/top_row/busy : status exported to the reader
//   master = environment side, slave = writer side.
// Revision    : 1.0  initial release
// ============================================================================
interface term_write_ctrl_if #(
  parameter int CHAR_W = 6
);
  logic [6:0]        char_in;
  logic              char_valid;
  logic              char_ready;
  logic              clr;
  logic [CHAR_W-1:0] mem_so;
  logic [CHAR_W-1:0] mem_si;
  logic [9:0]        head;
  logic [9:0]        cursor_addr;
  logic [4:0]        top_row;
  logic              busy;

  modport master (
    output char_in, char_valid, clr, mem_so,
    input  char_ready, mem_si, head, cursor_addr, top_row, busy
  );

  modport slave (
    input  char_in, char_valid, clr, mem_so,
    output char_ready, mem_si, head, cursor_addr, top_row, busy
  );
endinterface
`default_nettype wire

// File: rtl/term_cursor.sv
`default_nettype none
// ============================================================================
// Module      : term_cursor
// Description : Cursor position (col, logical row) and scroll origin
//               (top_row). Converts the logical position into a physical
//               memory address.
//   advance     : step one column; wraps into a newline at the last column
//   newline     : col=0, next row, or rotate top_row when on the bottom row
//   home        : col=0, lrow=0, top_row=0 (highest priority)
//   cursor_addr : row_phys*COLS + col
//   row_base    : row_phys*COLS
//   top_row     : physical row displayed first
//   scroll      : a newline now would scroll (cursor on bottom row)
//   eol         : cursor on last column
// Revision    : 1.0  initial release
// ============================================================================
module term_cursor
  import term_pkg::*;
#(
  parameter int COLS = term_pkg::COLS,
  parameter int ROWS = term_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  input  logic              newline,
  input  logic              home,
  output logic [ADDR_W-1:0] cursor_addr,
  output logic [ADDR_W-1:0] row_base,
  output logic [ROW_W-1:0]  top_row,
  output logic              scroll,
  output logic              eol
);

  localparam int                ROW_X_W  = ROW_W + 1;
  localparam logic [ROW_X_W-1:0] ROWS_X  = ROW_X_W'(ROWS);
  localparam logic [COL_W-1:0]  LAST_COL = COL_W'(COLS - 1);
  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(ROWS - 1);

  logic [COL_W-1:0]   col;
  logic [ROW_W-1:0]   lrow;
  logic [ROW_W-1:0]   top;
  logic [ROW_X_W-1:0] row_sum;
  logic [ROW_X_W-1:0] row_wrap;
  logic [ROW_W-1:0]   row_phys;
  logic               do_newline;

  // (top + lrow) mod ROWS; both operands are < ROWS so one subtraction suffices
  assign row_sum  = {1'b0, top} + {1'b0, lrow};
  assign row_wrap = row_sum - ROWS_X;
  assign row_phys = (row_sum >= ROWS_X) ? row_wrap[ROW_W-1:0] : row_sum[ROW_W-1:0];

  assign row_base    = row_start(row_phys, COLS);
  assign cursor_addr = row_base + ADDR_W'(col);
  assign top_row     = top;
  assign eol         = (col == LAST_COL);
  assign scroll      = (lrow == LAST_ROW);
  assign do_newline  = newline | (advance & eol);

  always_ff @(posedge clk) begin
    if (rst || home) begin
      col  <= '0;
      lrow <= '0;
      top  <= '0;
    end else if (do_newline) begin
      col <= '0;
      if (scroll) begin
        // bottom row stays the cursor row; the old top row becomes the bottom
        top <= (top == LAST_ROW) ? '0 : top + 1'b1;
      end else begin
        lrow <= lrow + 1'b1;
      end
    end else if (advance) begin
      col <= col + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/term_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : term_write_ctrl
// Description : Writer side of the recirculating character memory. Normally
//               feeds mem_so back into mem_si; substitutes the pending
//               character when the cursor slot reaches the tap, blanks the
//               new bottom row after a scroll and clears the whole memory on
//               reset or clr.
//   clk, rst : clock shared with the shift registers; sync active-high reset
//   bus      : term_write_ctrl_if.slave (handshake, memory tap, status)
// Revision    : 1.0  initial release
// ============================================================================
module term_write_ctrl
  import term_pkg::*;
#(
  parameter int CHAR_W    = 6,
  parameter int MEM_DEPTH = 1024,
  parameter int COLS      = term_pkg::COLS,
  parameter int ROWS      = term_pkg::ROWS
) (
  input  logic              clk,
  input  logic              rst,
  term_write_ctrl_if.slave  bus
);

  localparam logic [ADDR_W-1:0] LAST_HEAD = ADDR_W'(MEM_DEPTH - 1);
  localparam logic [ADDR_W-1:0] LAST_BLK  = ADDR_W'(COLS - 1);
  localparam logic [CHAR_W-1:0] SPACE     = CHAR_W'(BLANK_CHAR);

  logic [2:0]        state;
  logic [2:0]        state_nxt;
  logic [2:0]        scroll_state;
  logic [ADDR_W-1:0] head;
  logic [ADDR_W-1:0] head_nxt;
  logic [ADDR_W-1:0] cnt;
  logic [CHAR_W-1:0] char_q;
  logic [CHAR_W-1:0] mem_si;
  logic              ready;
  logic              advance;
  logic              newline;
  logic              home;
  logic [ADDR_W-1:0] cursor_addr;
  logic [ADDR_W-1:0] row_base;
  logic [ADDR_W-1:0] scroll_target;
  logic [ROW_W-1:0]  top_row;
  logic              scroll;
  logic              eol;
  logic              accept;
  logic              printable;
  logic              is_cr;

  term_cursor #(
    .COLS (COLS),
    .ROWS (ROWS)
  ) u_cursor (
    .clk         (clk),
    .rst         (rst),
    .advance     (advance),
    .newline     (newline),
    .home        (home),
    .cursor_addr (cursor_addr),
    .row_base    (row_base),
    .top_row     (top_row),
    .scroll      (scroll),
    .eol         (eol)
  );

  assign head_nxt  = (head == LAST_HEAD) ? '0 : head + 1'b1;
  assign accept    = ready & bus.char_valid & ~bus.clr;
  assign printable = (bus.char_in >= 7'h20);
  assign is_cr     = (bus.char_in == ASCII_CR);

  // On a scroll the current top row becomes the new bottom row to blank.
  // If the tap reaches its first address on the very next cycle, blanking
  // starts immediately; otherwise wait a pass so a row is never half blanked.
  assign scroll_target = row_start(top_row, COLS);
  assign scroll_state  = (head_nxt == scroll_target) ? ST_BLANK : ST_BLANK_WAIT;

  always_comb begin
    state_nxt = state;
    advance   = 1'b0;
    newline   = 1'b0;
    home      = 1'b0;
    mem_si    = bus.mem_so;
    case (state)
      ST_CLEAR: begin
        mem_si = SPACE;
        if (cnt == LAST_HEAD) begin
          state_nxt = ST_IDLE;
          home      = 1'b1;
        end
      end
      ST_IDLE: begin
        if (accept) begin
          if (printable)  state_nxt = ST_SEEK;
          else if (is_cr) state_nxt = ST_NEWLINE;
        end
      end
      ST_NEWLINE: begin
        newline   = 1'b1;
        state_nxt = scroll ? scroll_state : ST_IDLE;
      end
      ST_SEEK: begin
        if (head == cursor_addr) begin
          mem_si    = char_q;
          advance   = 1'b1;
          state_nxt = (eol && scroll) ? scroll_state : ST_IDLE;
        end
      end
      ST_BLANK_WAIT: begin
        if (head_nxt == row_base) state_nxt = ST_BLANK;
      end
      ST_BLANK: begin
        mem_si = SPACE;
        if (cnt == LAST_BLK) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase

    // clr aborts whatever is in flight, including a write on this cycle
    if (bus.clr) begin
      state_nxt = ST_CLEAR;
      advance   = 1'b0;
      newline   = 1'b0;
      home      = 1'b0;
      if (state != ST_CLEAR) mem_si = bus.mem_so;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_CLEAR;
      head   <= '0;
      cnt    <= '0;
      ready  <= 1'b0;
      char_q <= '0;
    end else begin
      state <= state_nxt;
      head  <= head_nxt;
      ready <= (state_nxt == ST_IDLE);
      // cycle counter restarts on every state entry and on each clr
      cnt   <= ((state_nxt != state) || bus.clr) ? '0 : cnt + 1'b1;
      if (accept && printable) char_q <= bus.char_in[CHAR_W-1:0];
    end
  end

  assign bus.char_ready  = ready;
  assign bus.mem_si      = mem_si;
  assign bus.head        = head;
  assign bus.cursor_addr = cursor_addr;
  assign bus.top_row     = top_row;
  assign bus.busy        = (state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_term_write_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_term_write_ctrl
// Description : Self-checking bench for term_write_ctrl with a behavioural
//               1024-entry memory and a screen-level reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_term_write_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;

  term_write_ctrl_if #(.CHAR_W(6)) bus_if ();

  term_write_ctrl #(
    .CHAR_W    (6),
    .MEM_DEPTH (1024),
    .COLS      (40),
    .ROWS      (24)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // behavioural recirculating memory
  logic [5:0] mem [1024];
  logic [9:0] tb_head;
  assign bus_if.mem_so = mem[tb_head];
  always @(posedge clk) begin
    mem[tb_head] <= bus_if.mem_si;
    if (rst) tb_head <= 10'd0;
    else     tb_head <= tb_head + 10'd1;
  end

  // screen-level reference model
  logic [5:0] exp_mem [1024];
  int m_col, m_lrow, m_top;
  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int mod1024(input int x);
    return ((x % 1024) + 1024) % 1024;
  endfunction

  function automatic int m_addr();
    return ((m_top + m_lrow) % 24) * 40 + m_col;
  endfunction

  function automatic int mem_mismatches();
    int n = 0;
    for (int i = 0; i < 1024; i++) if (mem[i] !== exp_mem[i]) n++;
    return n;
  endfunction

  task automatic m_home_blank();
    m_col = 0; m_lrow = 0; m_top = 0;
    for (int i = 0; i < 1024; i++) exp_mem[i] = 6'h20;
  endtask

  task automatic m_newline(output bit scrolled, output int tgt);
    m_col = 0; scrolled = 1'b0; tgt = 0;
    if (m_lrow < 23) m_lrow++;
    else begin
      tgt = m_top * 40;
      for (int i = 0; i < 40; i++) exp_mem[tgt + i] = 6'h20;
      m_top = (m_top + 1) % 24;
      scrolled = 1'b1;
    end
  endtask

  // starts at a negedge; counts cycles with ready low
  task automatic measure_low(output int low, output int nonblank);
    low = 0; nonblank = 0;
    while (bus_if.char_ready !== 1'b1 && low < 4000) begin
      if (bus_if.mem_si !== 6'h20) nonblank++;
      low++;
      @(negedge clk);
    end
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_cursor"}, 32'(bus_if.cursor_addr), 32'(m_addr()));
    check_eq({tag, "_top"}, 32'(bus_if.top_row), 32'(m_top));
    check_eq({tag, "_busy"}, 32'(bus_if.busy), 32'd0);
    check_eq({tag, "_head"}, 32'(bus_if.head), 32'(tb_head));
    check_eq({tag, "_mem"}, 32'(mem_mismatches()), 32'd0);
  endtask

  task automatic wait_ready(output bit ok);
    int n = 0;
    while (bus_if.char_ready !== 1'b1 && n < 5000) begin n++; @(negedge clk); end
    ok = (bus_if.char_ready === 1'b1);
  endtask

  // called at a negedge
  task automatic send_char(input logic [6:0] c, input int at_head);
    bit ok, scr;
    int low, nb, h_acc, addr, exp_low, tgt, n;
    wait_ready(ok);
    check_eq("ready_wait", 32'(ok), 32'd1);
    if (at_head >= 0) begin
      n = 0;
      while (int'(tb_head) != at_head && n < 2048) begin n++; @(negedge clk); end
    end
    h_acc = int'(tb_head);
    bus_if.char_in    = c;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    if (c >= 7'h20) begin
      addr = m_addr();
      exp_low = mod1024(addr - h_acc - 1) + 1;
      exp_mem[addr] = c[5:0];
      m_col++;
      if (m_col == 40) begin
        m_newline(scr, tgt);
        if (scr) exp_low += mod1024(tgt - addr - 1) + 1 + 39;
      end
    end else if (c == 7'h0D) begin
      m_newline(scr, tgt);
      exp_low = 1;
      if (scr) exp_low += mod1024(tgt - (h_acc + 1) - 1) + 1 + 39;
    end else begin
      exp_low = 0;
    end
    @(negedge clk);
    measure_low(low, nb);
    check_eq("latency", 32'(low), 32'(exp_low));
    check_state("op");
  endtask

  // called at a negedge; optional simultaneous character must be discarded
  task automatic do_clear(input bit with_char);
    int low, nb;
    bus_if.clr = 1'b1;
    if (with_char) begin
      bus_if.char_in    = 7'h44;
      bus_if.char_valid = 1'b1;
    end
    @(posedge clk);
    #1;
    bus_if.clr        = 1'b0;
    bus_if.char_valid = 1'b0;
    m_home_blank();
    @(negedge clk);
    measure_low(low, nb);
    check_eq("clr_low_cycles", 32'(low), 32'd1024);
    check_eq("clr_nonblank", 32'(nb), 32'd0);
    check_state("clr");
  endtask

  initial begin
    int low, nb, r;
    logic [6:0] c;
    bus_if.char_in    = 7'h00;
    bus_if.char_valid = 1'b0;
    bus_if.clr        = 1'b0;
    m_col = 0; m_lrow = 0; m_top = 0;

    // reset and initial clear pass
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_eq("rst_ready", 32'(bus_if.char_ready), 32'd0);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd1);
    check_eq("rst_cursor", 32'(bus_if.cursor_addr), 32'd0);
    check_eq("rst_top", 32'(bus_if.top_row), 32'd0);
    check_eq("rst_head", 32'(bus_if.head), 32'd0);
    measure_low(low, nb);
    check_eq("rst_low_cycles", 32'(low), 32'd1024);
    check_eq("rst_nonblank", 32'(nb), 32'd0);
    m_home_blank();
    check_state("rst");

    // 'A' accepted at head 500 lands at address 0
    send_char(7'h41, 500);
    check_eq("A_mem0", 32'(mem[0]), 32'h01);
    check_eq("A_cursor", 32'(bus_if.cursor_addr), 32'd1);

    // fill the rest of row 0
    for (int i = 0; i < 39; i++) send_char(7'h42, -1);
    check_eq("row0_cursor", 32'(bus_if.cursor_addr), 32'd40);

    // ignored control code
    send_char(7'h07, -1);

    // clr while a character is seeking, with another character offered
    send_char(7'h07, -1);
    bus_if.char_in    = 7'h43;
    bus_if.char_valid = 1'b1;
    @(posedge clk);
    #1 bus_if.char_valid = 1'b0;
    repeat (3) @(negedge clk);
    do_clear(1'b1);

    // mark row 0, then 24 CRs; the final one scrolls with zero wait
    send_char(7'h45, -1);
    for (int i = 0; i < 23; i++) send_char(7'h0D, -1);
    send_char(7'h0D, 1022);
    check_eq("scroll_top", 32'(bus_if.top_row), 32'd1);
    check_eq("scroll_cursor", 32'(bus_if.cursor_addr), 32'd0);
    check_eq("scroll_row0", 32'(mem[0]), 32'h20);

    // randomized traffic
    for (int k = 0; k < 24; k++) begin
      repeat ($urandom_range(0, 20)) @(negedge clk);
      r = $urandom_range(0, 99);
      if (r < 40)      c = 7'($urandom_range(32, 127));
      else if (r < 72) c = 7'h0D;
      else if (r < 92) begin
        c = 7'($urandom_range(0, 31));
        if (c == 7'h0D) c = 7'h07;
      end else c = 7'h00;
      if (r >= 92) do_clear(1'($urandom_range(0, 1)));
      else         send_char(c, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1500000;
    errors++;
    $display("FAIL watchdog: observed timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
